// File: rtl/q_8_9_datapath.sv
// rtl/q_8_9_datapath.sv - register datapath (A, E, F) for the q_8_9 controller
// Adds a saturating incr-cycle counter, a done pulse on F rising, and a sticky strobe-conflict flag.
module q_8_9_datapath #(
  parameter int A_WIDTH   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_A_F,
  input  logic                 incr_A,
  input  logic                 clr_E,
  input  logic                 set_E,
  input  logic                 set_F,
  output logic [A_WIDTH-1:0]   A,
  output logic                 A3,
  output logic                 A2,
  output logic                 E,
  output logic                 F,
  output logic [CNT_WIDTH-1:0] incr_count,
  output logic                 done,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [A_WIDTH-1:0]   a_next;
  logic                 e_next;
  logic                 f_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 conflict;

  always_comb begin
    a_next   = A;
    e_next   = E;
    f_next   = F;
    cnt_next = incr_count;

    if (clr_A_F) begin
      a_next   = '0;
      cnt_next = '0;
    end else if (incr_A) begin
      a_next = A + 1'b1;
      if (incr_count != CNT_MAX) cnt_next = incr_count + 1'b1;
    end

    // Simultaneous set_E and clr_E leaves E untouched.
    if (set_E && !clr_E)      e_next = 1'b1;
    else if (clr_E && !set_E) e_next = 1'b0;

    if (clr_A_F)    f_next = 1'b0;
    else if (set_F) f_next = 1'b1;

    conflict = (set_E && clr_E) || (clr_A_F && set_F);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A          <= '0;
      E          <= 1'b0;
      F          <= 1'b0;
      incr_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      A          <= a_next;
      E          <= e_next;
      F          <= f_next;
      incr_count <= cnt_next;
      // Pulse coincides with the first cycle F reads 1.
      done       <= !F && f_next;
      err        <= err || conflict;
    end
  end

  assign A3 = A[3];
  assign A2 = A[2];

endmodule

// File: tb/tb_q_8_9_datapath.sv
// tb/tb_q_8_9_datapath.sv - directed self-checking bench for q_8_9_datapath
module tb_q_8_9_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_A_F, incr_A, clr_E, set_E, set_F;
  logic [3:0] A;
  logic       A3, A2, E, F, done, err;
  logic [7:0] incr_count;

  int checks = 0;
  int errors = 0;

  q_8_9_datapath #(.A_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr_A_F(clr_A_F), .incr_A(incr_A),
    .clr_E(clr_E), .set_E(set_E), .set_F(set_F),
    .A(A), .A3(A3), .A2(A2), .E(E), .F(F),
    .incr_count(incr_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one set of strobes across a rising edge, then settle 1ns past it.
  task automatic step(input logic r, input logic caf, input logic inc,
                      input logic ce, input logic se, input logic sf);
    rst = r; clr_A_F = caf; incr_A = inc; clr_E = ce; set_E = se; set_F = sf;
    @(posedge clk);
    #1;
    rst = 1'b0; clr_A_F = 1'b0; incr_A = 1'b0; clr_E = 1'b0; set_E = 1'b0; set_F = 1'b0;
  endtask

  initial begin
    logic a2_now;
    logic a3a2;
    bit   looped;

    rst = 1'b1; clr_A_F = 1'b0; incr_A = 1'b0; clr_E = 1'b0; set_E = 1'b0; set_F = 1'b0;
    @(negedge clk);

    // Reset wins over random strobes
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("rst_A", A, 0);
    chk("rst_E", E, 0);
    chk("rst_F", F, 0);
    chk("rst_cnt", incr_count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Count to 13 with E following A2
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      a2_now = A2;
      step(0, 0, 1, !a2_now, a2_now, 0);
    end
    chk("cnt13_A", A, 13);
    chk("cnt13_A3", A3, 1);
    chk("cnt13_A2", A2, 1);
    chk("cnt13_E", E, 1);
    chk("cnt13_cnt", incr_count, 13);
    chk("cnt13_err", err, 0);

    // Wrap of A and saturation of incr_count
    step(0, 1, 0, 0, 0, 0);
    chk("clr_A", A, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);
    chk("wrap_A", A, 0);
    chk("wrap_cnt", incr_count, 16);
    for (int i = 0; i < 300; i++) step(0, 0, 1, 0, 0, 0);
    chk("sat_cnt", incr_count, 255);
    chk("sat_A", A, 12);

    // set_F pulse behaviour at A=7, then clr_A_F beats incr_A
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0);
    chk("a7_A", A, 7);
    step(0, 0, 0, 0, 0, 1);
    chk("setF_F", F, 1);
    chk("setF_done", done, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("done_width", done, 0);
    chk("F_hold", F, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("setF_again_done", done, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("clrinc_A", A, 0);
    chk("clrinc_cnt", incr_count, 0);
    chk("clrinc_F", F, 0);
    chk("clrinc_done", done, 0);
    chk("clrinc_err", err, 0);

    // E conflict, err stickiness
    step(0, 0, 0, 0, 1, 0);
    chk("setE_E", E, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("conflictE_E", E, 1);
    chk("conflictE_err", err, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("err_sticky_clr", err, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("clrE_E", E, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("clrF_conflict_F", F, 0);
    chk("clrF_conflict_err", err, 1);
    step(1, 0, 1, 0, 1, 1);
    chk("rst_err_clear", err, 0);
    chk("rst_mid_A", A, 0);
    chk("rst_mid_F", F, 0);

    // Closed loop as the controller would drive it
    step(0, 1, 0, 0, 0, 0);
    looped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a3a2   = A3 && A2;
      a2_now = A2;
      step(0, 0, 1, !a2_now, a2_now, 0);
      if (a3a2) begin
        looped = 1'b1;
        break;
      end
    end
    chk("loop_reached", looped, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("loop_F", F, 1);
    chk("loop_A", A, 13);
    chk("loop_E", E, 1);
    chk("loop_done", done, 1);
    chk("loop_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
